// File: rtl/mem_arb.sv
// mem_arb: two-requester arbiter (instruction fetch and load/store) onto a
// single memory port. Only one memory transaction is outstanding at a time.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   if_req_i, if_adr_i               fetch request and address
//   if_gnt_o, if_rvalid_o, if_rdata_o fetch grant, response valid, instruction
//   ls_req_i, ls_we_i, ls_adr_i,     load/store request, write enable, address,
//   ls_wdata_i, ls_size_i            store data, access size
//   ls_gnt_o, ls_rvalid_o, ls_rdata_o load/store grant, response valid, data
//   flush_i                          drops an outstanding fetch response
//   mem_req_o, mem_we_o, mem_adr_o,  shared memory request
//   mem_wdata_o, mem_size_o
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i memory grant and response
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to build the fetch
// starvation guard (after STARVE_MAX consecutive load/store grants taken while
// a fetch waits, the fetch wins the next arbitration). Without it, load/store
// has fixed priority.
//
// state    | meaning
// IDLE     | no transaction; arbitrate and drive winner straight to memory
// WAIT_GNT | request latched, holding mem_req_o until mem_gnt_i
// WAIT_RSP | granted, waiting for mem_rvalid_i to route back to the owner
module mem_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [31:0]     if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [XLEN-1:0] ls_adr_i,
  input  logic [XLEN-1:0] ls_wdata_i,
  input  logic [2:0]      ls_size_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [XLEN-1:0] ls_rdata_o,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t          state;
  owner_t          owner;
  logic            drop_q;
  logic            lat_we;
  logic [XLEN-1:0] lat_adr;
  logic [XLEN-1:0] lat_wdata;
  logic [2:0]      lat_size;

  logic            any_req;
  logic            ls_wins;
  logic            win_we;
  logic [XLEN-1:0] win_adr;
  logic [XLEN-1:0] win_wdata;
  logic [2:0]      win_size;

  assign any_req = if_req_i | ls_req_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;

  // Fetch overrides load/store only once the budget of skipped turns is used up.
  assign ls_wins = ls_req_i && !(if_req_i && (starve_cnt == STARVE_LIM));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_gnt_o) begin
      starve_cnt <= '0;
    end else if (ls_gnt_o && if_req_i && (starve_cnt != 4'hf)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign ls_wins = ls_req_i;
`endif

  // Fetch is always a 32-bit read.
  always_comb begin
    win_we    = 1'b0;
    win_adr   = if_adr_i;
    win_wdata = '0;
    win_size  = 3'b010;
    if (ls_wins) begin
      win_we    = ls_we_i;
      win_adr   = ls_adr_i;
      win_wdata = ls_wdata_i;
      win_size  = ls_size_i;
    end
  end

  // Outputs are combinational so grant and response add no latency; all of
  // them are forced low while reset is held.
  always_comb begin
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ls_gnt_o    = 1'b0;
    ls_rvalid_o = 1'b0;
    ls_rdata_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_adr_o   = '0;
    mem_wdata_o = '0;
    mem_size_o  = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_req_o   = 1'b1;
            mem_we_o    = win_we;
            mem_adr_o   = win_adr;
            mem_wdata_o = win_wdata;
            mem_size_o  = win_size;
            if (ls_wins) ls_gnt_o = mem_gnt_i;
            else         if_gnt_o = mem_gnt_i;
          end
        end
        WAIT_GNT: begin
          mem_req_o   = 1'b1;
          mem_we_o    = lat_we;
          mem_adr_o   = lat_adr;
          mem_wdata_o = lat_wdata;
          mem_size_o  = lat_size;
          if (owner == OWN_LS) ls_gnt_o = mem_gnt_i;
          else                 if_gnt_o = mem_gnt_i;
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            if (owner == OWN_LS) begin
              ls_rvalid_o = 1'b1;
              ls_rdata_o  = mem_rdata_i;
            end else if (!drop_q && !flush_i) begin
              // A flush arriving in the response cycle itself also drops it.
              if_rvalid_o = 1'b1;
              if_rdata_o  = mem_rdata_i[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      drop_q    <= 1'b0;
      lat_we    <= 1'b0;
      lat_adr   <= '0;
      lat_wdata <= '0;
      lat_size  <= '0;
    end else begin
      case (state)
        IDLE: begin
          drop_q <= 1'b0;
          if (any_req) begin
            owner     <= ls_wins ? OWN_LS : OWN_IF;
            lat_we    <= win_we;
            lat_adr   <= win_adr;
            lat_wdata <= win_wdata;
            lat_size  <= win_size;
            state     <= mem_gnt_i ? WAIT_RSP : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (flush_i && (owner == OWN_IF)) drop_q <= 1'b1;
          if (mem_gnt_i) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (flush_i && (owner == OWN_IF)) drop_q <= 1'b1;
          if (mem_rvalid_i) begin
            state  <= IDLE;
            drop_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
